// File: rtl/counter_timer_pkg.sv
// counter_timer_pkg: mode and state encodings shared by the counter/timer slice
package counter_timer_pkg;
  typedef enum logic [1:0] {FREE, ONESHOT, PINGPONG, RSVD} mode_t;
  typedef enum logic [1:0] {IDLE, RUN, STOPPED} state_t;
endpackage

// File: rtl/counter_timer_if.sv
// counter_timer_if: control, load handshake and status bundle of the counter/timer
interface counter_timer_if #(
  parameter int WIDTH = 8,
  parameter int PRESCALE_W = 8
) ();
  logic en;
  counter_timer_pkg::mode_t mode;
  logic dir;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] cmp;
  logic load_valid;
  logic [WIDTH-1:0] load_value;
  logic load_ready;
  logic [WIDTH-1:0] count;
  logic match;
  logic wrap;
  logic done;
  logic running;
  modport master (
    output en, mode, dir, prescale, top, cmp, load_valid, load_value,
    input load_ready, count, match, wrap, done, running
  );
  modport slave (
    input en, mode, dir, prescale, top, cmp, load_valid, load_value,
    output load_ready, count, match, wrap, done, running
  );
endinterface

// File: rtl/counter_prescaler.sv
// counter_prescaler: emits tick every prescale+1 cycles while run is high
module counter_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic clear,
  output logic tick
);
  localparam logic [PRESCALE_W-1:0] ONE = 1;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  assign tick = run && psc_q >= prescale;
  always_comb psc_d = (!run || clear || tick) ? '0 : psc_q + ONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) psc_q <= '0;
    else psc_q <= psc_d;
endmodule

// File: rtl/counter_timer.sv
// counter_timer: prescaled up/down counter with free-run, one-shot and ping-pong modes
module counter_timer
  import counter_timer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRESCALE_W = 8
) (
  input logic clk,
  input logic rst_n,
  counter_timer_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = 1;
  state_t state_q, state_d;
  logic dir_q, dir_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic match_q, match_d, wrap_q, wrap_d;
  logic run, tick, load_acc, at_end;
  assign run = state_q == RUN && bus.en;
  assign load_acc = bus.load_valid && bus.load_ready;
  assign at_end = dir_q ? count_q == '0 : count_q >= bus.top;
  counter_prescaler #(.PRESCALE_W(PRESCALE_W)) u_psc (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .prescale(bus.prescale),
    .clear(load_acc),
    .tick(tick)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = bus.en ? RUN : IDLE;
      RUN: state_d = !bus.en ? IDLE : (tick && at_end && bus.mode == ONESHOT) ? STOPPED : RUN;
      STOPPED: state_d = (load_acc || !bus.en) ? IDLE : STOPPED;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    count_d = count_q;
    dir_d = (load_acc || (state_q == IDLE && bus.en)) ? bus.dir : dir_q;
    if (load_acc) count_d = bus.load_value;
    else if (tick && !at_end) count_d = dir_q ? count_q - ONE : count_q + ONE;
    else if (tick)
      case (bus.mode)
        ONESHOT: count_d = count_q;
        PINGPONG: begin
          count_d = bus.top == '0 ? '0 : dir_q ? count_q + ONE : count_q - ONE;
          dir_d = ~dir_q;
        end
        default: count_d = dir_q ? bus.top : '0;
      endcase
    wrap_d = tick && at_end;
    match_d = (load_acc || tick) && count_d == bus.cmp;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q <= 1'b0;
      count_q <= '0;
      match_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      count_q <= count_d;
      match_q <= match_d;
      wrap_q <= wrap_d;
    end
  assign bus.load_ready = !tick;
  assign bus.count = count_q;
  assign bus.match = match_q;
  assign bus.wrap = wrap_q;
  assign bus.done = state_q == STOPPED;
  assign bus.running = state_q == RUN;
endmodule

// File: tb/tb_counter_timer.sv
// tb_counter_timer: table-driven scoreboard bench for counter_timer
module tb_counter_timer;
  import counter_timer_pkg::*;
  typedef struct {
    logic en;
    mode_t mode;
    logic dir;
    logic [7:0] psc;
    logic [7:0] top;
    logic [7:0] cmp;
    logic lv;
    logic [7:0] lval;
    logic [12:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;
  logic [12:0] exp_q[$];
  vec_t vecs[$];
  counter_timer_if #(.WIDTH(8), .PRESCALE_W(8)) bus ();
  counter_timer #(.WIDTH(8), .PRESCALE_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog");
  end
  function automatic vec_t r(input logic en, input mode_t mode, input logic dir,
                             input logic [7:0] psc, input logic [7:0] top, input logic [7:0] cmp,
                             input logic lv, input logic [7:0] lval, input logic [7:0] cnt,
                             input logic m, input logic w, input logic d, input logic run,
                             input logic rdy);
    vec_t v;
    v.en = en;
    v.mode = mode;
    v.dir = dir;
    v.psc = psc;
    v.top = top;
    v.cmp = cmp;
    v.lv = lv;
    v.lval = lval;
    v.exp = {cnt, m, w, d, run, rdy};
    return v;
  endfunction
  function automatic logic [12:0] outs();
    return {bus.count, bus.match, bus.wrap, bus.done, bus.running, bus.load_ready};
  endfunction
  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got {count,match,wrap,done,running,ready}=%h expected %h", name, act, exp);
  endtask
  task automatic drive(input vec_t v);
    bus.en = v.en;
    bus.mode = v.mode;
    bus.dir = v.dir;
    bus.prescale = v.psc;
    bus.top = v.top;
    bus.cmp = v.cmp;
    bus.load_valid = v.lv;
    bus.load_value = v.lval;
  endtask
  task automatic apply_check(input vec_t v, input string name);
    drive(v);
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    chk(name, outs(), exp_q.pop_front());
  endtask
  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    apply_check(v, name);
  endtask
  initial begin
    vec_t v;
    drive(r(0, FREE, 0, 0, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 1));
    #1 chk("reset_hold", outs(), 13'h0001);
    @(negedge clk) rst_n = 1'b1;
    step(r(0, FREE, 0, 0, 3, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 1), "after_reset");
    // free up, P=0, top=3
    vecs.push_back(r(1, FREE, 0, 0, 3, 8'hFF, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(r(1, FREE, 0, 0, 3, 8'hFF, 0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(r(1, FREE, 0, 0, 3, 8'hFF, 0, 0, 2, 0, 0, 0, 1, 0));
    vecs.push_back(r(1, FREE, 0, 0, 3, 8'hFF, 0, 0, 3, 0, 0, 0, 1, 0));
    vecs.push_back(r(1, FREE, 0, 0, 3, 8'hFF, 0, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(r(1, FREE, 0, 0, 3, 8'hFF, 0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(r(0, FREE, 0, 0, 3, 8'hFF, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(r(0, FREE, 0, 0, 3, 8'hFF, 1, 0, 0, 0, 0, 0, 0, 1));
    // free down, P=2, top=5
    vecs.push_back(r(1, FREE, 1, 2, 5, 8'hFF, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(r(1, FREE, 1, 2, 5, 8'hFF, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(r(1, FREE, 1, 2, 5, 8'hFF, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(r(1, FREE, 1, 2, 5, 8'hFF, 0, 0, 5, 0, 1, 0, 1, 1));
    vecs.push_back(r(1, FREE, 1, 2, 5, 8'hFF, 0, 0, 5, 0, 0, 0, 1, 1));
    vecs.push_back(r(1, FREE, 1, 2, 5, 8'hFF, 0, 0, 5, 0, 0, 0, 1, 0));
    vecs.push_back(r(1, FREE, 1, 2, 5, 8'hFF, 0, 0, 4, 0, 0, 0, 1, 1));
    vecs.push_back(r(0, FREE, 1, 2, 5, 8'hFF, 0, 0, 4, 0, 0, 0, 0, 1));
    vecs.push_back(r(0, FREE, 1, 2, 5, 8'hFF, 1, 0, 0, 0, 0, 0, 0, 1));
    // one-shot up, top=2
    vecs.push_back(r(1, ONESHOT, 0, 0, 2, 8'hFF, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(r(1, ONESHOT, 0, 0, 2, 8'hFF, 0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(r(1, ONESHOT, 0, 0, 2, 8'hFF, 0, 0, 2, 0, 0, 0, 1, 0));
    vecs.push_back(r(1, ONESHOT, 0, 0, 2, 8'hFF, 0, 0, 2, 0, 1, 1, 0, 1));
    vecs.push_back(r(1, ONESHOT, 0, 0, 2, 8'hFF, 0, 0, 2, 0, 0, 1, 0, 1));
    vecs.push_back(r(1, ONESHOT, 0, 0, 2, 8'hFF, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(r(1, ONESHOT, 0, 0, 2, 8'hFF, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(r(0, ONESHOT, 0, 0, 2, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 1));
    // ping-pong, top=2, cmp=1
    vecs.push_back(r(1, PINGPONG, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(r(1, PINGPONG, 0, 0, 2, 1, 0, 0, 1, 1, 0, 0, 1, 0));
    vecs.push_back(r(1, PINGPONG, 0, 0, 2, 1, 0, 0, 2, 0, 0, 0, 1, 0));
    vecs.push_back(r(1, PINGPONG, 0, 0, 2, 1, 0, 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(r(1, PINGPONG, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(r(1, PINGPONG, 0, 0, 2, 1, 0, 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(r(1, PINGPONG, 0, 0, 2, 1, 0, 0, 2, 0, 0, 0, 1, 0));
    vecs.push_back(r(0, PINGPONG, 0, 0, 2, 1, 0, 0, 2, 0, 0, 0, 0, 1));
    vecs.push_back(r(0, PINGPONG, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1));
    // load above top together with en rise
    vecs.push_back(r(1, FREE, 0, 0, 10, 8'hFF, 1, 200, 200, 0, 0, 0, 1, 0));
    vecs.push_back(r(1, FREE, 0, 0, 10, 8'hFF, 0, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(r(1, FREE, 0, 0, 10, 8'hFF, 0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(r(0, FREE, 0, 0, 10, 8'hFF, 0, 0, 1, 0, 0, 0, 0, 1));
    foreach (vecs[i]) step(vecs[i], $sformatf("row%0d", i));
    // load held across a tick cycle
    step(r(1, FREE, 0, 1, 10, 8'hFF, 0, 0, 1, 0, 0, 0, 1, 1), "lh_run");
    step(r(1, FREE, 0, 1, 10, 8'hFF, 0, 0, 1, 0, 0, 0, 1, 0), "lh_psc");
    v = r(1, FREE, 0, 1, 10, 8'hFF, 1, 50, 2, 0, 0, 0, 1, 1);
    @(negedge clk);
    drive(v);
    #1 chk("lh_ready_low", {12'd0, bus.load_ready}, 13'd0);
    apply_check(v, "lh_tick_wins");
    step(r(1, FREE, 0, 1, 10, 8'hFF, 1, 50, 50, 0, 0, 0, 1, 1), "lh_load_lands");
    step(r(1, FREE, 0, 1, 10, 8'hFF, 0, 0, 50, 0, 0, 0, 1, 0), "lh_psc_restart");
    step(r(0, FREE, 0, 1, 10, 8'hFF, 0, 0, 50, 0, 0, 0, 0, 1), "lh_stop");
    // asynchronous reset mid-count
    step(r(0, FREE, 0, 0, 20, 5, 1, 5, 5, 1, 0, 0, 0, 1), "rs_load_match");
    step(r(1, FREE, 0, 0, 20, 8, 0, 0, 5, 0, 0, 0, 1, 0), "rs_run");
    step(r(1, FREE, 0, 0, 20, 8, 0, 0, 6, 0, 0, 0, 1, 0), "rs_6");
    step(r(1, FREE, 0, 0, 20, 8, 0, 0, 7, 0, 0, 0, 1, 0), "rs_7");
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rs_async", outs(), 13'h0001);
    @(negedge clk);
    drive(r(0, FREE, 0, 0, 20, 8, 0, 0, 0, 0, 0, 0, 0, 1));
    rst_n = 1'b1;
    step(r(0, FREE, 0, 0, 20, 8, 0, 0, 0, 0, 0, 0, 0, 1), "rs_quiet0");
    step(r(0, FREE, 0, 0, 20, 8, 0, 0, 0, 0, 0, 0, 0, 1), "rs_quiet1");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
